// File: rtl/gpio_ctrl_pulse_gen.sv
// GPIO output pulse generator: inverts a latched pin mask for a programmable
// high phase, then restores it for a low phase, for N pulses or continuously.
module gpio_ctrl_pulse_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      gpio_out_reg,
  input  logic [31:0]      pulse_mask,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [CNT_W-1:0] low_cycles,
  input  logic [CNT_W-1:0] pulse_count,
  input  logic             start,
  input  logic             stop,
  output logic [31:0]      gpio_out_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_phase_cnt;
  logic [CNT_W-1:0] r_pulse_cnt;
  logic [31:0]      r_mask;
  logic [CNT_W-1:0] r_high_lat;
  logic [CNT_W-1:0] r_low_lat;
  logic [CNT_W-1:0] r_cnt_lat;
  logic             r_done;

  logic [CNT_W-1:0] w_high_eff;
  logic [CNT_W-1:0] w_low_eff;
  logic             w_last_pulse;

  // Zero-length phases are stretched to one cycle at latch time.
  assign w_high_eff   = (high_cycles == '0) ? LP_ONE : high_cycles;
  assign w_low_eff    = (low_cycles  == '0) ? LP_ONE : low_cycles;
  assign w_last_pulse = (r_cnt_lat != '0) && ((r_pulse_cnt + LP_ONE) == r_cnt_lat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_phase_cnt <= '0;
      r_pulse_cnt <= '0;
      r_mask      <= '0;
      r_high_lat  <= '0;
      r_low_lat   <= '0;
      r_cnt_lat   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_mask      <= pulse_mask;
              r_high_lat  <= w_high_eff;
              r_low_lat   <= w_low_eff;
              r_cnt_lat   <= pulse_count;
              r_phase_cnt <= w_high_eff - LP_ONE;
              r_pulse_cnt <= '0;
              r_state     <= ST_HIGH;
            end
          end
          ST_HIGH: begin
            if (r_phase_cnt != '0) begin
              r_phase_cnt <= r_phase_cnt - LP_ONE;
            end else begin
              r_phase_cnt <= r_low_lat - LP_ONE;
              r_state     <= ST_LOW;
            end
          end
          ST_LOW: begin
            if (r_phase_cnt != '0) begin
              r_phase_cnt <= r_phase_cnt - LP_ONE;
            end else if (w_last_pulse) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end else begin
              if (r_cnt_lat != '0) begin
                r_pulse_cnt <= r_pulse_cnt + LP_ONE;
              end
              r_phase_cnt <= r_high_lat - LP_ONE;
              r_state     <= ST_HIGH;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign gpio_out_data = gpio_out_reg ^ (r_mask & {32{r_state == ST_HIGH}});
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;

endmodule

// File: tb/tb_gpio_ctrl_pulse_gen.sv
// Bench for gpio_ctrl_pulse_gen: schedule-based reference model checked every
// cycle, plus directed literal expectations for each scenario.
module tb_gpio_ctrl_pulse_gen;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      gpio_out_reg;
  logic [31:0]      pulse_mask;
  logic [CNT_W-1:0] high_cycles;
  logic [CNT_W-1:0] low_cycles;
  logic [CNT_W-1:0] pulse_count;
  logic             start;
  logic             stop;
  logic [31:0]      gpio_out_data;
  logic             busy;
  logic             done;

  int n_tests = 0;
  int n_fail  = 0;

  gpio_ctrl_pulse_gen #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .gpio_out_reg  (gpio_out_reg),
    .pulse_mask    (pulse_mask),
    .high_cycles   (high_cycles),
    .low_cycles    (low_cycles),
    .pulse_count   (pulse_count),
    .start         (start),
    .stop          (stop),
    .gpio_out_data (gpio_out_data),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Model: a train is a position k (1 = first HIGH cycle) in a periodic schedule.
  bit          m_run  = 1'b0;
  bit          m_done = 1'b0;
  int          m_k    = 0;
  int          m_h    = 1;
  int          m_p    = 2;
  int          m_n    = 0;
  logic [31:0] m_mask = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  = 1'b0;
      m_done = 1'b0;
      m_k    = 0;
    end else begin
      m_done = 1'b0;
      if (m_run) begin
        if (stop) begin
          m_run = 1'b0;
        end else if (m_n != 0 && m_k == m_n * m_p) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end else begin
          m_k = m_k + 1;
        end
      end else if (start && !stop) begin
        m_h    = (high_cycles == 0) ? 1 : int'(high_cycles);
        m_p    = m_h + ((low_cycles == 0) ? 1 : int'(low_cycles));
        m_n    = int'(pulse_count);
        m_mask = pulse_mask;
        m_run  = 1'b1;
        m_k    = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic        hi;
    logic [31:0] exp_data;
    hi       = m_run && (((m_k - 1) % m_p) < m_h);
    exp_data = gpio_out_reg ^ (hi ? m_mask : 32'h0);
    chk("model_data", gpio_out_data, exp_data);
    chk("model_busy", {31'b0, busy}, {31'b0, m_run});
    chk("model_done", {31'b0, done}, {31'b0, m_done});
  end

  task automatic step();
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic launch(input logic [31:0] r, input logic [31:0] m, input int h,
                        input int l, input int n);
    gpio_out_reg = r;
    pulse_mask   = m;
    high_cycles  = CNT_W'(h);
    low_cycles   = CNT_W'(l);
    pulse_count  = CNT_W'(n);
    start        = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    gpio_out_reg = 32'hA5A5_0000;
    pulse_mask   = 32'hFFFF_FFFF;
    high_cycles  = '0;
    low_cycles   = '0;
    pulse_count  = '0;
    start        = 1'b0;
    stop         = 1'b0;

    // Reset sanity, including a start pulse while reset is held.
    repeat (3) step();
    chk("rst_data", gpio_out_data, 32'hA5A5_0000);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    start = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("rst_release_busy", {31'b0, busy}, 32'd0);
    chk("rst_release_data", gpio_out_data, 32'hA5A5_0000);

    // Single pulse: high=3, low=2, count=1.
    launch(32'h0, 32'h1, 3, 2, 1);
    step();
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("single_bit0_c%0d", c), {31'b0, gpio_out_data[0]},
          {31'b0, (c >= 1 && c <= 3)});
      chk($sformatf("single_busy_c%0d", c), {31'b0, busy}, {31'b0, (c <= 5)});
      chk($sformatf("single_done_c%0d", c), {31'b0, done}, {31'b0, (c == 6)});
      step();
    end

    // Multi-pulse with inversion of bits 31 and 0.
    launch(32'hFFFF_FFFF, 32'h8000_0001, 1, 1, 4);
    step();
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("multi_data_c%0d", c), gpio_out_data,
          ((c % 2 == 1) && c <= 7) ? 32'h7FFF_FFFE : 32'hFFFF_FFFF);
      chk($sformatf("multi_done_c%0d", c), {31'b0, done}, {31'b0, (c == 9)});
      step();
    end

    // Zero lengths behave as 1/1.
    launch(32'h0, 32'h10, 0, 0, 2);
    step();
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("zero_data_c%0d", c), gpio_out_data,
          (c == 1 || c == 3) ? 32'h10 : 32'h0);
      chk($sformatf("zero_done_c%0d", c), {31'b0, done}, {31'b0, (c == 5)});
      step();
    end

    // Continuous mode, stopped in cycle 11.
    launch(32'h0000_00F0, 32'h0000_000F, 2, 2, 0);
    step();
    for (int c = 1; c <= 13; c++) begin
      if (c == 9 || c == 10 || c == 5 || c == 1)
        chk($sformatf("cont_high_c%0d", c), gpio_out_data, 32'h0000_00FF);
      if (c == 11 || c == 8)
        chk($sformatf("cont_low_c%0d", c), gpio_out_data, 32'h0000_00F0);
      chk($sformatf("cont_busy_c%0d", c), {31'b0, busy}, {31'b0, (c <= 11)});
      chk($sformatf("cont_done_c%0d", c), {31'b0, done}, 32'd0);
      if (c == 11) stop = 1'b1;
      step();
    end
    chk("cont_idle_data", gpio_out_data, 32'h0000_00F0);

    // Start and stop together: stop wins.
    launch(32'h0, 32'h1, 1, 1, 1);
    stop = 1'b1;
    step();
    chk("startstop_busy", {31'b0, busy}, 32'd0);
    step();
    chk("startstop_busy2", {31'b0, busy}, 32'd0);

    // Start while busy with new config; new config used only after done.
    launch(32'h1234_0000, 32'h1, 2, 1, 2);
    step();
    for (int c = 1; c <= 18; c++) begin
      if (c == 1) chk("busycfg_c1", gpio_out_data, 32'h1234_0001);
      if (c == 4) chk("busycfg_c4", gpio_out_data, 32'h5678_0001);
      if (c == 6) chk("busycfg_c6", gpio_out_data, 32'h5678_0000);
      if (c == 7) chk("busycfg_done_c7", {31'b0, done}, 32'd1);
      if (c == 8) chk("busycfg_newcfg_c8", gpio_out_data, 32'h5678_00F0);
      if (c == 12) chk("busycfg_newhigh_c12", gpio_out_data, 32'h5678_00F0);
      if (c == 13) chk("busycfg_newlow_c13", gpio_out_data, 32'h5678_0000);
      if (c == 17) chk("busycfg_done_c17", {31'b0, done}, 32'd1);
      if (c == 2) begin
        start       = 1'b1;
        pulse_mask  = 32'hF0;
        high_cycles = CNT_W'(5);
        low_cycles  = CNT_W'(4);
        pulse_count = CNT_W'(1);
      end
      if (c == 3) gpio_out_reg = 32'h5678_0000;
      if (c == 7) start = 1'b1;
      step();
    end

    // Reset asserted mid-train.
    launch(32'h0000_0F00, 32'h0000_0FF0, 4, 4, 3);
    step();
    step();
    chk("midrst_pre_busy", {31'b0, busy}, 32'd1);
    chk("midrst_pre_data", gpio_out_data, 32'h0000_00F0);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_data", gpio_out_data, 32'h0000_0F00);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("midrst_after_busy", {31'b0, busy}, 32'd0);
    chk("midrst_after_done", {31'b0, done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl_pulse_gen.md
Name: gpio_ctrl_pulse_gen

Overview:
Output-direction counterpart to the GPIO input edge/interrupt path: generates timed edges on GPIO output pins instead of detecting them on inputs. When started, it inverts a latched mask of output pins for a programmable high phase, then restores them for a programmable low phase. It repeats for N pulses, or continuously until stopped. Sits between the output-data register and the pad output mux in the GPIO controller.

Parameters:
CNT_W, 16, width of the phase-length and pulse-count fields

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous assert, active-low
gpio_out_reg  input  32  static output value from the register block
pulse_mask  input  32  pins driven by the generator; sampled on accepted start
high_cycles  input  CNT_W  active-phase length in cycles; sampled on accepted start
low_cycles  input  CNT_W  idle-phase length in cycles; sampled on accepted start
pulse_count  input  CNT_W  number of pulses; 0 = continuous; sampled on accepted start
start  input  1  single-cycle request to begin a pulse train
stop  input  1  single-cycle abort request
gpio_out_data  output  32  value to pads
busy  output  1  generator active
done  output  1  one-cycle pulse on natural completion

Behaviour:
- Reset values: state IDLE, phase counter 0, pulse counter 0, latched mask 0, busy 0, done 0.
- Output during reset and in IDLE: gpio_out_data = gpio_out_reg, i.e. the mask contributes nothing.
- gpio_out_data = gpio_out_reg ^ (mask_lat & {32{state==HIGH}}).
  - Combinational from the state register and the live gpio_out_reg.
  - No glitch path from start, stop or config inputs.
- busy = (state != IDLE); driven from the state register.
- FSM states: IDLE, HIGH, LOW.
- IDLE, start=1, stop=0:
  - Latch mask, high_lat, low_lat and cnt_lat.
  - A high or low length of 0 is treated as 1.
  - Go to HIGH with phase_cnt = high_lat-1 and pulse_cnt = 0.
  - First HIGH cycle is the cycle after start is sampled.
- HIGH:
  - If phase_cnt != 0, decrement it.
  - Else go to LOW with phase_cnt = low_lat-1.
  - Net effect: exactly high_lat cycles in HIGH.
- LOW:
  - If phase_cnt != 0, decrement it.
  - Else, when cnt_lat != 0 and pulse_cnt+1 == cnt_lat: go to IDLE and assert done for exactly the first IDLE cycle.
  - Otherwise increment pulse_cnt (only when cnt_lat != 0), go to HIGH, and reload phase_cnt = high_lat-1.
  - Net effect: exactly low_lat cycles in LOW.
- Continuous mode (cnt_lat == 0): pulse_cnt is held and never wraps; the train runs until stop.
- stop=1 in any state:
  - Next state IDLE; done stays 0.
  - Pins return to gpio_out_reg in the next cycle.
  - stop has priority over start in the same cycle.
- start while busy is ignored. Config changes while busy have no effect until the next accepted start.
- Period = high_lat + low_lat cycles. For N pulses, busy is high for N*(high_lat+low_lat) cycles.
- Reset asserted mid-train: immediate return to IDLE, outputs at reset values, no done.
- gpio_out_reg changes while busy: reflected on the next cycle on every pin. Masked pins show the inverted value while in HIGH.

Test Plan:
- Reset sanity:
  - Stimulus: hold rst_n=0 with gpio_out_reg=0xA5A5_0000.
  - Required: gpio_out_data=0xA5A5_0000, busy=0, done=0.
  - Then assert start during reset: still no activity after reset release.
- Single pulse:
  - Stimulus: gpio_out_reg=0, mask=0x1, high=3, low=2, count=1, start at cycle 0.
  - Required: bit0=1 in cycles 1-3, 0 in cycles 4-5.
  - busy=1 in cycles 1-5; done=1 only in cycle 6.
- Multi-pulse with inversion:
  - Stimulus: gpio_out_reg=0xFFFF_FFFF, mask=0x8000_0001, high=1, low=1, count=4.
  - Required: bits 31 and 0 read 0 on cycles 1, 3, 5, 7 and 1 elsewhere.
  - done in cycle 9; other bits constantly 1.
- Zero lengths:
  - Stimulus: high=0, low=0, count=2.
  - Required: behaves as high=1, low=1; done in cycle 5.
- Continuous and stop:
  - Stimulus: count=0, high=2, low=2; stop in cycle 11.
  - Required: period 4 sustained through cycle 11; IDLE from cycle 12 with output = gpio_out_reg and done never asserted.
  - Then start and stop in the same cycle: remains IDLE.
- Start while busy and config change:
  - Stimulus: while busy, pulse start and change mask/high/low.
  - Required: train timing and mask are unchanged; the new config is used only by a start accepted after done.
